lcd_frame_sequencer: RTL and testbench

LCD_FRAME_SEQUENCER -- requirements
Module: lcd_frame_sequencer

---
 rtl/lcd_frame_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_lcd_frame_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_frame_sequencer.sv
// Sequences INIT / CLEAR / 56-character frame writes to an LCD controller
// from a 32x8 host-written frame buffer, with per-phase handshake timeout.
module lcd_frame_sequencer #(
    parameter int unsigned NCOMMANDS = 5,
    parameter logic [23:0] TIMEOUT   = 24'd1000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [4:0]           wr_addr,
    input  logic [7:0]           wr_data,
    input  logic                 refresh,
    input  logic                 init_req,
    input  logic                 lcd_rdy,
    output logic                 lcd_en,
    output logic [NCOMMANDS:0]   lcd_op,
    output logic [7:0]           lcd_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int unsigned OPW       = NCOMMANDS + 1;
    localparam int unsigned PTRW      = 6;
    localparam int unsigned CNTW      = 24;
    localparam int unsigned DEPTH     = 32;
    localparam logic [PTRW-1:0] PTR_INIT  = 6'd0;
    localparam logic [PTRW-1:0] PTR_CLEAR = 6'd1;
    localparam logic [PTRW-1:0] PTR_LAST  = 6'd57;
    localparam logic [7:0]      SPACE     = 8'h20;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        STROBE,
        WAIT_ACK,
        WAIT_DONE,
        NEXT
    } state_e;

    state_e            state_q, state_d;
    logic [PTRW-1:0]   ptr_q, ptr_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              pend_init_q, pend_init_d;
    logic              pend_ref_q, pend_ref_d;
    logic              en_q, en_d;
    logic [OPW-1:0]    op_q, op_d;
    logic [7:0]        data_q, data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [7:0]        mem_q [DEPTH];

    logic [PTRW-1:0]   k_c;
    logic [7:0]        char_c;
    logic [OPW-1:0]    op_c;
    logic              timeout_c;

    // Frame buffer: host writes land at the next edge regardless of FSM state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= SPACE;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Map op pointer to command and character; line 2 starts at DDRAM 0x40
    always_comb begin
        k_c    = ptr_q - 6'd2;
        op_c   = '0;
        char_c = 8'h00;
        if (ptr_q == PTR_INIT) begin
            op_c[0] = 1'b1;
        end else if (ptr_q == PTR_CLEAR) begin
            op_c[1] = 1'b1;
        end else begin
            op_c[2] = 1'b1;
            if (k_c < 6'd16) begin
                char_c = mem_q[k_c[4:0]];
            end else if (k_c < 6'd40) begin
                char_c = SPACE;
            end else begin
                char_c = mem_q[5'(k_c - 6'd24)];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            pend_init_q <= 1'b0;
            pend_ref_q  <= 1'b0;
            en_q        <= 1'b0;
            op_q        <= '0;
            data_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            pend_init_q <= pend_init_d;
            pend_ref_q  <= pend_ref_d;
            en_q        <= en_d;
            op_q        <= op_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        pend_init_d = pend_init_q;
        pend_ref_d  = pend_ref_q;
        en_d        = 1'b0;
        op_d        = op_q;
        data_d      = data_q;
        done_d      = 1'b0;
        err_d       = err_q;
        timeout_c   = (cnt_q == TIMEOUT - 24'd1);

        // Requests while busy are remembered; a pending init subsumes a refresh
        if (state_q != IDLE) begin
            if (init_req) begin
                pend_init_d = 1'b1;
                pend_ref_d  = 1'b0;
            end else if (refresh && !pend_init_q) begin
                pend_ref_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (init_req || pend_init_q) begin
                    state_d     = ARM;
                    ptr_d       = PTR_INIT;
                    cnt_d       = '0;
                    err_d       = 1'b0;
                    pend_init_d = 1'b0;
                    pend_ref_d  = 1'b0;
                end else if (refresh || pend_ref_q) begin
                    state_d     = ARM;
                    ptr_d       = PTR_CLEAR;
                    cnt_d       = '0;
                    pend_init_d = 1'b0;
                    pend_ref_d  = 1'b0;
                end
            end
            ARM: begin
                if (lcd_rdy) begin
                    state_d = STROBE;
                    en_d    = 1'b1;
                    op_d    = op_c;
                    data_d  = char_c;
                end else if (timeout_c) begin
                    state_d     = IDLE;
                    err_d       = 1'b1;
                    pend_init_d = 1'b0;
                    pend_ref_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            STROBE: begin
                state_d = WAIT_ACK;
                cnt_d   = '0;
            end
            WAIT_ACK: begin
                if (!lcd_rdy) begin
                    state_d = WAIT_DONE;
                    cnt_d   = '0;
                end else if (timeout_c) begin
                    state_d     = IDLE;
                    err_d       = 1'b1;
                    pend_init_d = 1'b0;
                    pend_ref_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            WAIT_DONE: begin
                if (lcd_rdy) begin
                    state_d = NEXT;
                end else if (timeout_c) begin
                    state_d     = IDLE;
                    err_d       = 1'b1;
                    pend_init_d = 1'b0;
                    pend_ref_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            NEXT: begin
                if (ptr_q == PTR_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ARM;
                    ptr_d   = ptr_q + 6'd1;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign lcd_en   = en_q;
    assign lcd_op   = op_q;
    assign lcd_data = data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Scoreboard bench for lcd_frame_sequencer: stimulus queues expected strobes and
// done pulses, a forked monitor pops and compares them as the DUT emits them.
module tb_lcd_frame_sequencer;

    typedef struct packed {
        logic       kind;   // 0 = strobe, 1 = done
        logic [5:0] op;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       refresh;
    logic       init_req;
    logic       lcd_rdy;
    logic       lcd_en;
    logic [5:0] lcd_op;
    logic [7:0] lcd_data;
    logic       busy;
    logic       done;
    logic       err;

    exp_t       exp_q[$];
    logic [7:0] mdl [32];
    int         total = 0;
    int         bad = 0;
    int         strobes = 0;
    logic       hold_low = 1'b0;

    lcd_frame_sequencer #(
        .NCOMMANDS (5),
        .TIMEOUT   (24'd16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .refresh  (refresh),
        .init_req (init_req),
        .lcd_rdy  (lcd_rdy),
        .lcd_en   (lcd_en),
        .lcd_op   (lcd_op),
        .lcd_data (lcd_data),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Controller model: drops rdy on a strobe, raises it again 3 cycles later
    task automatic ctl_model();
        int cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                lcd_rdy = 1'b1;
                cnt = 0;
            end else if (hold_low) begin
                lcd_rdy = 1'b0;
            end else if (lcd_en) begin
                lcd_rdy = 1'b0;
                cnt = 3;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) lcd_rdy = 1'b1;
            end else begin
                lcd_rdy = 1'b1;
            end
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (lcd_en) begin
                    strobes++;
                    chk("strobe expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("strobe kind", 32'(e.kind), 32'd0);
                        chk("strobe op", 32'(lcd_op), 32'(e.op));
                        chk("strobe data", 32'(lcd_data), 32'(e.data));
                    end
                end
                if (done) begin
                    chk("done expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("done kind", 32'(e.kind), 32'd1);
                    end
                    chk("busy low with done", 32'(busy), 32'd0);
                end
            end
        end
    endtask

    function automatic logic [7:0] exp_char(input int k);
        if (k < 16) return mdl[k];
        else if (k < 40) return 8'h20;
        else return mdl[k-24];
    endfunction

    task automatic push_seq(input bit with_init);
        if (with_init) exp_q.push_back('{1'b0, 6'h01, 8'h00});
        exp_q.push_back('{1'b0, 6'h02, 8'h00});
        for (int k = 0; k < 56; k++) exp_q.push_back('{1'b0, 6'h04, exp_char(k)});
        exp_q.push_back('{1'b1, 6'h00, 8'h00});
    endtask

    task automatic pulse(input logic r, input logic i);
        @(negedge clk);
        refresh  = r;
        init_req = i;
        @(negedge clk);
        refresh  = 1'b0;
        init_req = 1'b0;
    endtask

    task automatic buf_write(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        mdl[a]  = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int c = 0;
        while ((exp_q.size() != 0 || busy) && c < 3000) begin
            @(negedge clk);
            c++;
        end
        chk({name, " leftover expectations"}, 32'(exp_q.size()), 32'd0);
        chk({name, " busy after sequence"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int base;
        int n;
        rst      = 1'b1;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        refresh  = 1'b0;
        init_req = 1'b0;
        lcd_rdy  = 1'b1;
        for (int i = 0; i < 32; i++) mdl[i] = 8'h20;
        fork
            ctl_model();
            monitor();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst lcd_en", 32'(lcd_en), 32'd0);
        chk("rst lcd_op", 32'(lcd_op), 32'd0);
        chk("rst lcd_data", 32'(lcd_data), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst err", 32'(err), 32'd0);
        rst = 1'b0;

        // Refresh of a blank buffer
        base = strobes;
        push_seq(1'b0);
        pulse(1'b1, 1'b0);
        chk("busy rises on request", 32'(busy), 32'd1);
        wait_idle("refresh blank");
        chk("refresh strobe count", 32'(strobes - base), 32'd57);

        // Letters then init
        for (int i = 0; i < 16; i++) buf_write(5'(i), 8'(8'h41 + i));
        for (int i = 0; i < 16; i++) buf_write(5'(16 + i), 8'(8'h61 + i));
        base = strobes;
        push_seq(1'b1);
        pulse(1'b0, 1'b1);
        wait_idle("init letters");
        chk("init strobe count", 32'(strobes - base), 32'd58);

        // Simultaneous init and refresh: init only
        base = strobes;
        push_seq(1'b1);
        pulse(1'b1, 1'b1);
        wait_idle("init+refresh");
        repeat (20) @(negedge clk);
        chk("no trailing refresh busy", 32'(busy), 32'd0);
        chk("init+refresh strobe count", 32'(strobes - base), 32'd58);

        // Refresh while busy queues a second refresh
        base = strobes;
        push_seq(1'b0);
        push_seq(1'b0);
        pulse(1'b1, 1'b0);
        repeat (20) @(negedge clk);
        pulse(1'b1, 1'b0);
        n = 0;
        while (!done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("first done seen", 32'(done), 32'd1);
        @(negedge clk);
        chk("pending restarts after done", 32'(busy), 32'd1);
        wait_idle("pending refresh");
        chk("two refresh strobe count", 32'(strobes - base), 32'd114);

        // Timeout with lcd_rdy held low
        hold_low = 1'b1;
        repeat (2) @(negedge clk);
        base = strobes;
        pulse(1'b1, 1'b0);
        n = 0;
        for (int c = 0; c < 100 && busy; c++) begin
            n++;
            @(negedge clk);
        end
        chk("timeout busy cycles", 32'(n), 32'd16);
        chk("timeout err", 32'(err), 32'd1);
        chk("timeout busy", 32'(busy), 32'd0);
        chk("timeout no strobe", 32'(strobes - base), 32'd0);
        hold_low = 1'b0;
        repeat (3) @(negedge clk);
        push_seq(1'b0);
        pulse(1'b1, 1'b0);
        wait_idle("refresh with err");
        chk("err sticky over refresh", 32'(err), 32'd1);
        push_seq(1'b1);
        pulse(1'b0, 1'b1);
        chk("init clears err", 32'(err), 32'd0);
        wait_idle("init after err");

        // Reset during WRITE index 20
        base = strobes;
        push_seq(1'b0);
        pulse(1'b1, 1'b0);
        n = 0;
        while (strobes < base + 22 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("reached write 20", 32'(strobes >= base + 22), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid rst lcd_en", 32'(lcd_en), 32'd0);
        chk("mid rst lcd_op", 32'(lcd_op), 32'd0);
        chk("mid rst lcd_data", 32'(lcd_data), 32'd0);
        chk("mid rst busy", 32'(busy), 32'd0);
        chk("mid rst done", 32'(done), 32'd0);
        chk("mid rst err", 32'(err), 32'd0);
        exp_q.delete();
        for (int i = 0; i < 32; i++) mdl[i] = 8'h20;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        base = strobes;
        repeat (10) @(negedge clk);
        chk("no strobe after reset", 32'(strobes - base), 32'd0);
        push_seq(1'b0);
        pulse(1'b1, 1'b0);
        wait_idle("refresh after reset");
        chk("post-reset strobe count", 32'(strobes - base), 32'd57);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
